// File: rtl/rot_tile_buffer.sv
// Ping-pong N x N pixel tile buffer: fills one bank in raster order while the other
// drains through a single output register in rotated (0/90/180/270, CW/CCW) order.
module rot_tile_buffer #(
    parameter int DATA_W    = 32,
    parameter int TILE_LOG2 = 2
) (
    input  logic              I_HCLK,
    input  logic              I_HRESET,
    input  logic              I_CLEAR,
    input  logic [1:0]        I_DEGREES,
    input  logic              I_DIRECTION,
    input  logic              I_WR_VALID,
    input  logic [DATA_W-1:0] I_WR_DATA,
    output logic              O_WR_READY,
    output logic              O_RD_VALID,
    output logic [DATA_W-1:0] O_RD_DATA,
    input  logic              I_RD_READY,
    output logic              O_TILE_DONE,
    output logic              O_BUSY
);

    localparam int N    = 1 << TILE_LOG2;
    localparam int NPIX = N * N;
    localparam int CW   = 2 * TILE_LOG2;

    localparam logic [CW-1:0] LAST_IDX = CW'(NPIX - 1);

    localparam logic [1:0] S_EMPTY    = 2'd0;
    localparam logic [1:0] S_FILLING  = 2'd1;
    localparam logic [1:0] S_FULL     = 2'd2;
    localparam logic [1:0] S_DRAINING = 2'd3;

    logic [DATA_W-1:0]    r_mem [2][NPIX];
    logic [1:0]           r_state [2];
    logic [2:0]           r_mode [2];
    logic                 r_wrSel;
    logic                 r_rdSel;
    logic [CW-1:0]        r_wcnt;
    logic [CW-1:0]        r_rcnt;
    logic                 r_rdValid;
    logic [DATA_W-1:0]    r_rdData;
    logic                 r_rdLast;
    logic                 r_tileDone;

    logic                 w_wrAccept;
    logic                 w_load;
    logic                 w_rdHandshake;
    logic [2:0]           w_mode;
    logic [1:0]           w_angle;
    logic [TILE_LOG2-1:0] w_orow;
    logic [TILE_LOG2-1:0] w_ocol;
    logic [TILE_LOG2-1:0] w_srow;
    logic [TILE_LOG2-1:0] w_scol;
    logic [CW-1:0]        w_srcIdx;

    assign O_WR_READY    = !I_HRESET &&
                           (r_state[r_wrSel] == S_EMPTY || r_state[r_wrSel] == S_FILLING);
    assign w_wrAccept    = I_WR_VALID && O_WR_READY;
    assign w_rdHandshake = r_rdValid && I_RD_READY;
    assign w_load        = (r_state[r_rdSel] == S_FULL || r_state[r_rdSel] == S_DRAINING) &&
                           (!r_rdValid || I_RD_READY);

    assign O_RD_VALID  = r_rdValid;
    assign O_RD_DATA   = r_rdData;
    assign O_TILE_DONE = r_tileDone;
    assign O_BUSY      = (r_state[0] != S_EMPTY) || (r_state[1] != S_EMPTY) || r_rdValid;

    // CCW rotation by d equals CW rotation by (4-d) mod 4; N-1-x is just ~x here.
    always_comb begin
        w_mode  = r_mode[r_rdSel];
        w_angle = w_mode[2] ? (2'd0 - w_mode[1:0]) : w_mode[1:0];
        w_orow  = r_rcnt[CW-1:TILE_LOG2];
        w_ocol  = r_rcnt[TILE_LOG2-1:0];
        w_srow  = w_orow;
        w_scol  = w_ocol;
        case (w_angle)
            2'd1: begin w_srow = ~w_ocol; w_scol = w_orow;  end
            2'd2: begin w_srow = ~w_orow; w_scol = ~w_ocol; end
            2'd3: begin w_srow = w_ocol;  w_scol = ~w_orow; end
            default: ;
        endcase
        w_srcIdx = {w_srow, w_scol};
    end

    always_ff @(posedge I_HCLK) begin
        if (w_wrAccept) begin
            r_mem[r_wrSel][r_wcnt] <= I_WR_DATA;
        end
    end

    always_ff @(posedge I_HCLK) begin
        if (I_HRESET || I_CLEAR) begin
            for (int b = 0; b < 2; b++) begin
                r_state[b] <= S_EMPTY;
                r_mode[b]  <= 3'd0;
            end
            r_wrSel    <= 1'b0;
            r_rdSel    <= 1'b0;
            r_wcnt     <= '0;
            r_rcnt     <= '0;
            r_rdValid  <= 1'b0;
            r_rdLast   <= 1'b0;
            r_tileDone <= 1'b0;
            if (I_HRESET) begin
                r_rdData <= '0;
            end
        end else begin
            // Write and read never target the same bank, so both updates can land together.
            if (w_wrAccept) begin
                if (r_wcnt == '0) begin
                    r_mode[r_wrSel] <= {I_DIRECTION, I_DEGREES};
                end
                if (r_wcnt == LAST_IDX) begin
                    r_state[r_wrSel] <= S_FULL;
                    r_wrSel          <= ~r_wrSel;
                    r_wcnt           <= '0;
                end else begin
                    r_state[r_wrSel] <= S_FILLING;
                    r_wcnt           <= r_wcnt + CW'(1);
                end
            end

            if (w_load) begin
                r_rdData  <= r_mem[r_rdSel][w_srcIdx];
                r_rdValid <= 1'b1;
                r_rdLast  <= (r_rcnt == LAST_IDX);
                if (r_rcnt == LAST_IDX) begin
                    r_state[r_rdSel] <= S_EMPTY;
                    r_rdSel          <= ~r_rdSel;
                    r_rcnt           <= '0;
                end else begin
                    r_state[r_rdSel] <= S_DRAINING;
                    r_rcnt           <= r_rcnt + CW'(1);
                end
            end else if (w_rdHandshake) begin
                r_rdValid <= 1'b0;
            end

            r_tileDone <= w_rdHandshake && r_rdLast;
        end
    end

endmodule
